alu_issue_scheduler: RTL

Reservation station and issue scheduler in front of the integer ALU. It accepts decoded ALU/branch/address ops from dispatch, holds them until both operands are available, captures operand values broadcast by the ALU and load/store result buses, and issues at most one ready op per cycle to the ALU. It sits between decoder/rename and the ALU; ALU results return to it as one of the two wakeup buses.

---
 rtl/alu_issue_scheduler_pkg.sv | 61 ++++++
 rtl/alu_issue_scheduler_rr_select.sv | 18 +
 rtl/alu_issue_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_issue_scheduler_pkg.sv
// alu_issue_scheduler_pkg: shared widths, op encodings and entry types for the ALU reservation station
package alu_issue_scheduler_pkg;
    localparam int OP_WIDTH     = 7;
    localparam int VAL_WIDTH    = 32;
    localparam int ROB_ID_WIDTH = 3;
    localparam int ADDR_WIDTH   = 32;
    localparam int TAG_WIDTH    = ROB_ID_WIDTH + 1;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD   = 7'h00,
        OP_SUB   = 7'h01,
        OP_AND   = 7'h02,
        OP_OR    = 7'h03,
        OP_XOR   = 7'h04,
        OP_SLL   = 7'h05,
        OP_SRL   = 7'h06,
        OP_SRA   = 7'h07,
        OP_SLT   = 7'h08,
        OP_SLTU  = 7'h09,
        OP_BEQ   = 7'h10,
        OP_BNE   = 7'h11,
        OP_BLT   = 7'h12,
        OP_BGE   = 7'h13,
        OP_JAL   = 7'h20,
        OP_JALR  = 7'h21,
        OP_AUIPC = 7'h30,
        OP_LUI   = 7'h31
    } op_type_e;

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;
        logic [VAL_WIDTH-1:0] val;
    } operand_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [VAL_WIDTH-1:0] val;
    } cdb_t;

    typedef struct packed {
        logic                  valid;
        logic [OP_WIDTH-1:0]   op;
        operand_t              src1;
        operand_t              src2;
        logic [TAG_WIDTH-1:0]  rob;
        logic [ADDR_WIDTH-1:0] pc;
    } rs_entry_t;

    // Capture a broadcast into a pending operand; the ALU bus wins when both match.
    function automatic operand_t wake(operand_t o, cdb_t a, cdb_t l);
        operand_t r;
        r = o;
        if (o.busy && a.valid && a.tag == o.tag)
            r = '{busy: 1'b0, tag: o.tag, val: a.val};
        else if (o.busy && l.valid && l.tag == o.tag)
            r = '{busy: 1'b0, tag: o.tag, val: l.val};
        return r;
    endfunction
endpackage

// File: rtl/alu_issue_scheduler_rr_select.sv
// alu_issue_scheduler_rr_select: round-robin picker, first ready index at or after the pointer
module alu_issue_scheduler_rr_select #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] ready,
    input  logic [W-1:0] ptr,
    output logic         gnt,
    output logic [W-1:0] idx
);
    // N is a power of two, so W-bit addition wraps the scan naturally.
    always_comb begin
        gnt = |ready;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (ready[ptr + W'(i)]) idx = ptr + W'(i);
    end
endmodule

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: reservation station holding ALU ops until operands arrive, issuing one per cycle
module alu_issue_scheduler
    import alu_issue_scheduler_pkg::*;
#(
    parameter int RS_SIZE      = 8,
    parameter int RS_IDX_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  disp_valid,
    input  logic [OP_WIDTH-1:0]   disp_type,
    input  logic [VAL_WIDTH-1:0]  disp_val1,
    input  logic [VAL_WIDTH-1:0]  disp_val2,
    input  logic                  disp_busy1,
    input  logic                  disp_busy2,
    input  logic [TAG_WIDTH-1:0]  disp_tag1,
    input  logic [TAG_WIDTH-1:0]  disp_tag2,
    input  logic [TAG_WIDTH-1:0]  disp_entry,
    input  logic [ADDR_WIDTH-1:0] disp_pc,
    output logic                  rs_full,
    input  logic                  alu_cdb_valid,
    input  logic [TAG_WIDTH-1:0]  alu_cdb_entry,
    input  logic [VAL_WIDTH-1:0]  alu_cdb_val,
    input  logic                  lsb_cdb_valid,
    input  logic [TAG_WIDTH-1:0]  lsb_cdb_entry,
    input  logic [VAL_WIDTH-1:0]  lsb_cdb_val,
    output logic                  execute,
    output logic [OP_WIDTH-1:0]   ex_type,
    output logic [VAL_WIDTH-1:0]  ex_val1,
    output logic [VAL_WIDTH-1:0]  ex_val2,
    output logic [TAG_WIDTH-1:0]  ex_entry,
    output logic [ADDR_WIDTH-1:0] ex_pc
);
    rs_entry_t             ent [RS_SIZE];
    logic [RS_SIZE-1:0]    valid_v;
    logic [RS_SIZE-1:0]    ready_v;
    logic [RS_IDX_WIDTH-1:0] rr;
    logic [RS_IDX_WIDTH-1:0] idx;
    logic [RS_IDX_WIDTH-1:0] free_idx;
    logic                  gnt;
    cdb_t                  alu;
    cdb_t                  lsb;

    assign alu = '{valid: alu_cdb_valid, tag: alu_cdb_entry, val: alu_cdb_val};
    assign lsb = '{valid: lsb_cdb_valid, tag: lsb_cdb_entry, val: lsb_cdb_val};

    always_comb begin
        valid_v  = '0;
        ready_v  = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            valid_v[i] = ent[i].valid;
            ready_v[i] = ent[i].valid && !ent[i].src1.busy && !ent[i].src2.busy;
            if (!ent[i].valid) free_idx = RS_IDX_WIDTH'(i);
        end
    end

    assign rs_full = &valid_v;

    alu_issue_scheduler_rr_select #(.N(RS_SIZE), .W(RS_IDX_WIDTH)) u_rr (
        .ready(ready_v),
        .ptr  (rr),
        .gnt  (gnt),
        .idx  (idx)
    );

    // Dispatch targets an invalid slot, so it never collides with wakeup or issue of a valid one.
    always_ff @(posedge clk) begin
        if (!rst_n_in || flush) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
            rr       <= '0;
            execute  <= 1'b0;
            ex_type  <= '0;
            ex_val1  <= '0;
            ex_val2  <= '0;
            ex_entry <= '0;
            ex_pc    <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++)
                if (ent[i].valid) begin
                    ent[i].src1 <= wake(ent[i].src1, alu, lsb);
                    ent[i].src2 <= wake(ent[i].src2, alu, lsb);
                end
            execute <= gnt;
            if (gnt) begin
                ex_type         <= ent[idx].op;
                ex_val1         <= ent[idx].src1.val;
                ex_val2         <= ent[idx].src2.val;
                ex_entry        <= ent[idx].rob;
                ex_pc           <= ent[idx].pc;
                ent[idx].valid  <= 1'b0;
                rr              <= idx + RS_IDX_WIDTH'(1);
            end
            if (disp_valid && !rs_full)
                ent[free_idx] <= '{
                    valid: 1'b1,
                    op:    disp_type,
                    src1:  wake('{busy: disp_busy1, tag: disp_tag1, val: disp_val1}, alu, lsb),
                    src2:  wake('{busy: disp_busy2, tag: disp_tag2, val: disp_val2}, alu, lsb),
                    rob:   disp_entry,
                    pc:    disp_pc
                };
        end
    end
endmodule
